// File: rtl/dino_pkg.sv
// Shared types and constants for the Dino score keeper and its
// seven-segment display driver.
package dino_pkg;

    typedef logic [3:0]      bcd_t;
    typedef logic [3:0][3:0] score_t;

    typedef enum logic [1:0] {D0, D1, D2, D3} scan_state_e;

    // Active-low glyphs, bit order g..a
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int DEF_CLK_HZ   = 50_000_000;
    localparam int DEF_TICK_DIV = 5_000_000;
    localparam int DEF_SCAN_DIV = 50_000;

    function automatic logic [6:0] seg_glyph(input bcd_t d);
        logic [6:0] g;
        g = SEG_BLANK;
        if (d <= 4'd9) begin
            g = SEG_DIGIT[d];
        end
        return g;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Game-state inputs and display pins of the score keeper, grouped so the
// game logic and the driver connect through one bundle.
interface score_display_if;

    logic       run;
    logic       game_over;
    logic       restart;
    logic       show_hi;
    logic [7:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output run, game_over, restart, show_hi,
        input  seg, an, dp
    );

    modport slave (
        input  run, game_over, restart, show_hi,
        output seg, an, dp
    );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD score register: ripple-carry increment that sticks at 9999,
// with a synchronous clear that wins over the increment.
module bcd_counter4
    import dino_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr_i,
    input  logic   inc_i,
    output score_t value_o,
    output logic   max_o
);

    score_t value_q;
    score_t value_d;
    logic   carry;

    assign max_o   = (value_q == 16'h9999);
    assign value_o = value_q;

    always_comb begin
        value_d = value_q;
        carry   = 1'b1;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i && !max_o) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (value_q[i] == 4'd9) begin
                        value_d[i] = 4'd0;
                    end else begin
                        value_d[i] = value_q[i] + 4'd1;
                        carry      = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/score_display.sv
// Dino score keeper: tick divider, live/high score, and a multiplexed
// 4-digit seven-segment driver with leading-zero blanking.
module score_display
    import dino_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic            clk,
    input  logic            clr,
    score_display_if.slave  bus
);

    // Tick counter is wide enough for any divider up to one second of clocks
    localparam int TW = $clog2((TICK_DIV > CLK_HZ ? TICK_DIV : CLK_HZ) + 1);
    localparam int SW = $clog2(SCAN_DIV > 1 ? SCAN_DIV : 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          cnt_en;
    logic          tick;
    score_t        score;
    logic          score_max;

    logic          go_q;
    logic          rise_q;
    score_t        snap_q;
    score_t        hi_q;

    scan_state_e   idx_q;
    logic [SW-1:0] scnt_q;
    logic [7:0]    seg_q;
    logic [3:0]    an_q;
    logic          dp_q;

    score_t        disp;
    bcd_t          digit;
    logic          blank;
    logic [6:0]    glyph;
    logic [3:0]    an_d;

    assign cnt_en = bus.run & ~bus.game_over;
    assign tick   = cnt_en & (tcnt_q == TICK_LAST);

    always_comb begin
        tcnt_d = tcnt_q;
        if (bus.restart) begin
            tcnt_d = '0;
        end else if (cnt_en) begin
            tcnt_d = tick ? '0 : tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    bcd_counter4 u_score (
        .clk     (clk),
        .rst_n   (clr),
        .clr_i   (bus.restart),
        .inc_i   (tick & ~score_max),
        .value_o (score),
        .max_o   (score_max)
    );

    // Score is snapshotted on the edge that sees game_over rise, so a
    // simultaneous restart cannot rob the high score of the final value.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            go_q   <= 1'b0;
            rise_q <= 1'b0;
            snap_q <= '0;
            hi_q   <= '0;
        end else begin
            go_q   <= bus.game_over;
            rise_q <= bus.game_over & ~go_q;
            snap_q <= score;
            if (rise_q && (snap_q > hi_q)) begin
                hi_q <= snap_q;
            end
        end
    end

    always_comb begin
        disp  = bus.show_hi ? hi_q : score;
        digit = disp[idx_q];
        blank = 1'b0;
        unique case (idx_q)
            D0: blank = 1'b0;
            D1: blank = (disp[3] == 4'd0) && (disp[2] == 4'd0) && (disp[1] == 4'd0);
            D2: blank = (disp[3] == 4'd0) && (disp[2] == 4'd0);
            D3: blank = (disp[3] == 4'd0);
        endcase
        glyph = blank ? SEG_BLANK : seg_glyph(digit);
        an_d  = ~(4'b0001 << idx_q);
    end

    // Digit-scan FSM; the pins are registered here from the current index
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            scnt_q <= '0;
            idx_q  <= D0;
            seg_q  <= 8'hFF;
            an_q   <= 4'hF;
            dp_q   <= 1'b1;
        end else begin
            if (scnt_q == SCAN_LAST) begin
                scnt_q <= '0;
                unique case (idx_q)
                    D0: idx_q <= D1;
                    D1: idx_q <= D2;
                    D2: idx_q <= D3;
                    D3: idx_q <= D0;
                endcase
            end else begin
                scnt_q <= scnt_q + SW'(1);
            end
            an_q  <= an_d;
            seg_q <= {~bus.show_hi, glyph};
            dp_q  <= ~bus.show_hi;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: a behavioural model predicts the pins
// for every edge, expectations are queued before the edge and popped after.
module tb_score_display;

    localparam int TD = 4;
    localparam int SD = 2;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #10 clk = ~clk;

    score_display_if bus();

    score_display #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [12:0] sbQ [$];
    logic [12:0] expV;
    logic [12:0] actV;

    int mScore, mHi, mTcnt, mSnap, mIdx, mScnt;
    bit mGoQ, mRiseQ;

    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int pw [4] = '{1, 10, 100, 1000};

    task automatic modelReset();
        mScore = 0; mHi = 0; mTcnt = 0; mSnap = 0;
        mIdx = 0; mScnt = 0; mGoQ = 0; mRiseQ = 0;
    endtask

    // Pins expected after the coming edge, packed as {an, seg, dp}
    function automatic logic [12:0] modelPins();
        int v, d;
        bit blank;
        logic [6:0] s;
        logic [3:0] a;
        logic p;
        v     = bus.show_hi ? mHi : mScore;
        d     = (v / pw[mIdx]) % 10;
        blank = (mIdx > 0) && (v < pw[mIdx]);
        s     = blank ? 7'h7F : glyph[d];
        p     = ~bus.show_hi;
        a     = 4'b0001 << mIdx;
        return {~a, p, s, p};
    endfunction

    task automatic modelAdvance();
        bit cntEn, tick;
        cntEn = bus.run && !bus.game_over;
        tick  = cntEn && (mTcnt == TD - 1);
        if (mRiseQ && (mSnap > mHi)) mHi = mSnap;
        mRiseQ = bus.game_over && !mGoQ;
        mSnap  = mScore;
        mGoQ   = bus.game_over;
        if (bus.restart) begin
            mScore = 0;
            mTcnt  = 0;
        end else begin
            if (tick && mScore < 9999) mScore++;
            if (cntEn) mTcnt = tick ? 0 : mTcnt + 1;
        end
        if (mScnt == SD - 1) begin
            mScnt = 0;
            mIdx  = (mIdx + 1) % 4;
        end else begin
            mScnt++;
        end
    endtask

    task automatic applyStimulus();
        sbQ.push_back(modelPins());
        modelAdvance();
        @(posedge clk);
        #1;
        actV = {bus.an, bus.seg, bus.dp};
        expV = sbQ.pop_front();
    endtask

    task automatic test_reset();
        clr = 1'b0;
        bus.run = 0; bus.game_over = 0; bus.restart = 0; bus.show_hi = 0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({bus.an, bus.seg, bus.dp} !== {4'hF, 8'hFF, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: actual {an,seg,dp}=%h required %h",
                     {bus.an, bus.seg, bus.dp}, {4'hF, 8'hFF, 1'b1});
        end
        clr = 1'b1;
        modelReset();
        applyStimulus();
        compared++;
        if (actV !== {4'hE, 8'hC0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL first_edge: actual %h required %h", actV, {4'hE, 8'hC0, 1'b1});
        end
        repeat (8) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL reset_scan: actual %h required %h", actV, expV);
            end
        end
    endtask

    task automatic test_counting();
        bus.run = 1'b1;
        repeat (42) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL counting: actual %h required %h", actV, expV);
            end
        end
    endtask

    task automatic test_high_score();
        bus.game_over = 1'b1;
        repeat (8) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL freeze: actual %h required %h", actV, expV);
            end
        end
        bus.show_hi = 1'b1;
        repeat (8) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL show_hi: actual %h required %h", actV, expV);
            end
        end
        compared++;
        if (actV[8] !== 1'b0 || actV[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hi_dp: actual seg7=%b dp=%b required 0 0", actV[8], actV[0]);
        end
    endtask

    task automatic test_restart();
        bus.game_over = 1'b0;
        bus.show_hi   = 1'b0;
        for (int i = 0; i < TD && mTcnt != TD - 1; i++) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL pre_restart: actual %h required %h", actV, expV);
            end
        end
        bus.restart = 1'b1;
        applyStimulus();
        bus.restart = 1'b0;
        repeat (7 * TD + 3) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL after_restart: actual %h required %h", actV, expV);
            end
        end
        bus.game_over = 1'b1;
        bus.show_hi   = 1'b1;
        repeat (10) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL hi_kept: actual %h required %h", actV, expV);
            end
        end
    endtask

    task automatic test_saturation();
        bus.game_over = 1'b0;
        bus.show_hi   = 1'b0;
        for (int i = 0; i < 45000 && mScore < 9998; i++) applyStimulus();
        repeat (4 * TD + 4) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL saturate: actual %h required %h", actV, expV);
            end
        end
        repeat (8) begin
            applyStimulus();
            compared++;
            if (actV[7:1] !== 7'h10) begin
                mismatched++;
                $display("[TB] FAIL sat_digit: actual %h required 10", actV[7:1]);
            end
        end
        bus.game_over = 1'b1;
        bus.show_hi   = 1'b1;
        repeat (10) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL hi_9999: actual %h required %h", actV, expV);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.game_over = 1'b0;
        bus.show_hi   = 1'b0;
        repeat (6) applyStimulus();
        #5 clr = 1'b0;
        #1;
        compared++;
        if ({bus.an, bus.seg, bus.dp} !== {4'hF, 8'hFF, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL async_reset: actual %h required %h",
                     {bus.an, bus.seg, bus.dp}, {4'hF, 8'hFF, 1'b1});
        end
        @(posedge clk);
        #1;
        clr = 1'b1;
        modelReset();
        bus.show_hi = 1'b1;
        repeat (8) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL hi_cleared: actual %h required %h", actV, expV);
            end
        end
        bus.show_hi = 1'b0;
        repeat (12) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL recount: actual %h required %h", actV, expV);
            end
        end
    endtask

    task automatic test_restart_gameover();
        bus.game_over = 1'b1;
        bus.restart   = 1'b1;
        bus.show_hi   = 1'b1;
        applyStimulus();
        bus.restart = 1'b0;
        repeat (10) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL restart_go: actual %h required %h", actV, expV);
            end
        end
        bus.show_hi = 1'b0;
        repeat (8) begin
            applyStimulus();
            compared++;
            if (actV !== expV) begin
                mismatched++;
                $display("[TB] FAIL score_zeroed: actual %h required %h", actV, expV);
            end
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_high_score();
        test_restart();
        test_saturation();
        test_async_reset();
        test_restart_gameover();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/score_display.md
# score_display

Score keeper and 4-digit seven-segment driver for the Dino game. Instantiated inside `main`, it sits downstream of the game-state logic and drives the board's `seg`/`an`/`dp` pins. While a run is active it advances a 4-digit BCD score at a fixed rate. It latches the high score at game over and time-multiplexes either score onto the display with leading-zero blanking.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency (20 ns period).
- `TICK_DIV`, default 5_000_000: clocks per score increment (10 points/s).
- `SCAN_DIV`, default 50_000: clocks per digit slot (1 kHz digit rate, 250 Hz refresh).
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `clr`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: game in progress; enables score counting.
- `game_over`, in, 1: level signal; freezes the score while high.
- `restart`, in, 1: synchronous one-cycle pulse; zeroes the score.
- `show_hi`, in, 1: level signal; 1 displays the high score, 0 displays the live score.
- `seg`, out, 8: `seg[6:0]` = segments g..a, active-low; `seg[7]` mirrors `dp`.
- `an`, out, 4: digit enables, active-low; `an[0]` is the rightmost (ones) digit.
- `dp`, out, 1: decimal point, active-low.

## Operation
- Counting enable: `cnt_en = run & ~game_over`.
- Tick counter:
  - 0..TICK_DIV-1; advances only while `cnt_en`; holds otherwise.
  - Wrapping to 0 produces a 1-cycle `tick`.
- Score:
  - 4 BCD digits, each 0..9, ripple carry.
  - On `tick`: score += 1.
  - Saturates at 9999; a tick at 9999 leaves it at 9999.
- Restart:
  - `restart` zeroes the score and the tick counter.
  - It beats a same-cycle `tick`.
  - It does not touch the high score.
- High score:
  - Updated on the registered rising edge of `game_over`: if score > hi then hi ← score.
  - Cleared only by `clr`.
- Display source: `show_hi` selects the digit vector (hi or score), sampled per digit slot.
- Scan:
  - Scan counter 0..SCAN_DIV-1; its wrap advances the digit index 0→1→2→3→0.
  - `an` = one-hot-low of the index.
- Blanking: the thousands, hundreds and tens digits blank (seg[6:0] = 7'h7F) when they and every higher digit are 0. The ones digit never blanks.
- Glyphs: 0..9 encode to standard active-low patterns, e.g. '0' = 7'h40, '1' = 7'h79, '8' = 7'h00.
- dp: 0 (lit) on all digits while `show_hi`=1, else 1.
- States: the scan index is the only FSM, states D0..D3. Transitions happen only on scan wrap, unconditionally cyclic.

## Timing
- Reset values while `clr`=0:
  - score = 0, hi = 0, counters = 0, index = D0.
  - `an` = 4'hF, `seg` = 8'hFF, `dp` = 1.
- All outputs are registered.
- First edge after `clr` release: `an` = 4'hE, `seg` = 8'hC0 (ones '0', dp off).
- Output latency: `seg`/`an`/`dp` reflect the index, score and `show_hi` of the previous cycle (1-cycle latency).
- Score update: lands the cycle after the tick counter reaches TICK_DIV-1. It is visible on the pins one cycle later.
- `game_over` edge → hi updated 2 cycles after the input rises (edge register + compare/load).
- Simultaneous `game_over` rise and `tick`: the tick is suppressed (`cnt_en`=0), so hi captures the pre-tick score.
- Simultaneous `restart` and `game_over` rise: hi captures the old score, then the score becomes 0.
- `clr` asserted mid-scan forces reset values immediately (asynchronous); nothing is preserved.

## Structure
- Package `dino_pkg`:
  - BCD digit type (4 bits) and score type (4×4 bits).
  - SEG_DIGIT[0:9] constant table, SEG_BLANK = 7'h7F.
  - Default divider constants.
- Sub-module `bcd_counter4`: 4-digit saturating BCD incrementer with sync clear, an `inc` input and a `max` flag.
- Top contains the tick divider, high-score compare, scan FSM, blanking and output registers.

## Test plan
Run with TICK_DIV=4 and SCAN_DIV=2 unless stated.
1. Reset: hold `clr`=0 → `an`=F, `seg`=FF, `dp`=1. Release `clr` → next edge `an`=E, `seg`=C0; the index cycles E→D→B→7 every 2 clocks, with digits 1–3 blank (7F).
2. Counting: `run`=1 for 40 clocks → score = 10. The display shows `an`=E with '0' (C0) and `an`=D with '1' (F9); the hundreds and thousands digits stay blank.
3. Freeze and high score: raise `game_over` with score = 10 → the score holds; hi = 10 two cycles later. `show_hi`=1 → the same digits appear with `dp`=0 and `seg[7]`=0.
4. Restart: pulse `restart` in the same cycle as a tick → score = 0 and hi stays 10. A later run to 7 followed by `game_over` leaves hi = 10 (7 < 10).
5. Saturation: preload the score to 9998 via ticks (TICK_DIV=1), then 3 more ticks → 9999 held, all four digits show '9' (seg[6:0] = 7'h10).
6. Async reset mid-run: drop `clr` between clock edges during counting → outputs reach reset values before the next edge, and score and hi are both 0 after release.
